// File: rtl/mem_unit_burst_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mem_unit_burst_if
// Description : Request/ready bus carrying burst commands into mem_unit_burst
//               and read data back out of it.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface mem_unit_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 2
);
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  burst_len;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              burst_done;

  // Controller side: issues commands, consumes read data
  modport master (
    output req, rw, addr, burst_len, data_in,
    input  ready, data_out, data_valid, burst_done
  );

  // Memory side: accepts commands, returns read data
  modport slave (
    input  req, rw, addr, burst_len, data_in,
    output ready, data_out, data_valid, burst_done
  );
endinterface
`default_nettype wire

// File: rtl/mem_unit_burst.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mem_unit_burst
// Description : Single-port synchronous memory, DEPTH = 2**ADDR_W words,
//               with incrementing wrap-around bursts of burst_len+1 beats,
//               one beat per clock, 1-cycle read latency and a burst_done
//               pulse after the final beat.
//               Optional macro MEM_WR_ECHO_EN: write beats also load
//               data_out and raise data_valid, with read timing.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_unit_burst #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 2
) (
  input  wire                  clk,
  input  wire                  rst_n,
  mem_unit_burst_if.slave      bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_rem;
  logic                r_rw;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_valid;
  logic                r_burst_done;

  logic                w_beat;
  logic                w_accept;
  logic                w_last;
  logic [ADDR_W-1:0]   w_beat_addr;
  logic                w_beat_rw;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_state_next;
  end

  // Next state and beat decode; beat 0 uses the live bus, later beats
  // use the latched command so bus changes mid-burst are ignored
  always_comb begin
    w_state_next = r_state;
    w_beat       = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_beat_addr  = r_addr;
    w_beat_rw    = r_rw;
    case (r_state)
      INIT: w_state_next = IDLE;
      IDLE: begin
        if (bus.req) begin
          w_beat      = 1'b1;
          w_accept    = 1'b1;
          w_beat_addr = bus.addr;
          w_beat_rw   = bus.rw;
          w_last      = (bus.burst_len == '0);
          if (!w_last) w_state_next = BURST;
        end
      end
      BURST: begin
        w_beat = 1'b1;
        w_last = (r_rem == LEN_W'(1));
        if (w_last) w_state_next = IDLE;
      end
      default: w_state_next = INIT;
    endcase
  end

  // Burst bookkeeping: next address (wraps modulo DEPTH), beats left, direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_rw   <= 1'b0;
    end else if (w_beat) begin
      r_addr <= w_beat_addr + 1'b1;
      if (w_accept) begin
        r_rem <= bus.burst_len;
        r_rw  <= bus.rw;
      end else begin
        r_rem <= r_rem - 1'b1;
      end
    end
  end

  // Storage array, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_beat && !w_beat_rw) begin
      r_mem[w_beat_addr] <= bus.data_in;
    end
  end

  // Read data path, valid for the cycle after each beat that produces data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_beat && w_beat_rw) begin
        r_data_out   <= r_mem[w_beat_addr];
        r_data_valid <= 1'b1;
      end
`ifdef MEM_WR_ECHO_EN
      else if (w_beat && !w_beat_rw) begin
        r_data_out   <= bus.data_in;
        r_data_valid <= 1'b1;
      end
`endif
    end
  end

  // One-cycle completion pulse after the final beat edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_burst_done <= 1'b0;
    else        r_burst_done <= w_beat && w_last;
  end

  assign bus.ready      = (r_state == IDLE);
  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.burst_done = r_burst_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_unit_burst.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_mem_unit_burst
// Description : Directed self-checking bench for mem_unit_burst.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mem_unit_burst;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mem_unit_burst_if #(.DATA_W(8), .ADDR_W(4), .LEN_W(2)) bus ();

  mem_unit_burst #(.DATA_W(8), .ADDR_W(4), .LEN_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic r, input logic [3:0] a, input logic [1:0] l, input logic [7:0] d);
    bus.req       = 1'b1;
    bus.rw        = r;
    bus.addr      = a;
    bus.burst_len = l;
    bus.data_in   = d;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b1;
    bus.req       = 1'b0;
    bus.rw        = 1'b0;
    bus.addr      = '0;
    bus.burst_len = '0;
    bus.data_in   = '0;

    // Asynchronous reset with no clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_data_out", 32'(bus.data_out), 32'h00);
    check("rst_valid",    32'(bus.data_valid), 32'h0);
    check("rst_ready",    32'(bus.ready), 32'h0);
    check("rst_done",     32'(bus.burst_done), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("init_ready", 32'(bus.ready), 32'h1);
    check("init_done",  32'(bus.burst_done), 32'h0);

    // Single read of cleared word
    cmd(1'b1, 4'd5, 2'd0, 8'h00);
    tick();
    bus.req = 1'b0;
    check("rd5_data",  32'(bus.data_out), 32'h00);
    check("rd5_valid", 32'(bus.data_valid), 32'h1);
    check("rd5_done",  32'(bus.burst_done), 32'h1);
    check("rd5_ready", 32'(bus.ready), 32'h1);
    tick();
    check("rd5_valid_off", 32'(bus.data_valid), 32'h0);
    check("rd5_done_off",  32'(bus.burst_done), 32'h0);

    // Single write then single read of addr 3
    cmd(1'b0, 4'd3, 2'd0, 8'hA5);
    tick();
    bus.req = 1'b0;
    check("wr3_done", 32'(bus.burst_done), 32'h1);
`ifdef MEM_WR_ECHO_EN
    check("wr3_echo_valid", 32'(bus.data_valid), 32'h1);
    check("wr3_echo_data",  32'(bus.data_out), 32'hA5);
`else
    check("wr3_valid", 32'(bus.data_valid), 32'h0);
`endif
    tick();
    cmd(1'b1, 4'd3, 2'd0, 8'h00);
    tick();
    bus.req = 1'b0;
    check("rd3_data",  32'(bus.data_out), 32'hA5);
    check("rd3_valid", 32'(bus.data_valid), 32'h1);
    check("rd3_done",  32'(bus.burst_done), 32'h1);
    tick();
    check("rd3_valid_off", 32'(bus.data_valid), 32'h0);
    check("rd3_hold",      32'(bus.data_out), 32'hA5);

    // Wrap-around write burst 14,15,0,1
    cmd(1'b0, 4'd14, 2'd3, 8'd1);
    tick();
    check("wwr_b0_ready", 32'(bus.ready), 32'h0);
    check("wwr_b0_done",  32'(bus.burst_done), 32'h0);
    bus.data_in = 8'd2;
    tick();
    check("wwr_b1_ready", 32'(bus.ready), 32'h0);
    bus.data_in = 8'd3;
    tick();
    check("wwr_b2_ready", 32'(bus.ready), 32'h0);
    check("wwr_b2_done",  32'(bus.burst_done), 32'h0);
    bus.data_in = 8'd4;
    tick();
    bus.req = 1'b0;
    check("wwr_end_ready", 32'(bus.ready), 32'h1);
    check("wwr_end_done",  32'(bus.burst_done), 32'h1);
    tick();
    check("wwr_done_off", 32'(bus.burst_done), 32'h0);

    // Read burst from 14; req held with rw=0 mid-burst must not write
    cmd(1'b1, 4'd14, 2'd3, 8'h00);
    tick();
    check("rbr_b0_data",  32'(bus.data_out), 32'd1);
    check("rbr_b0_valid", 32'(bus.data_valid), 32'h1);
    cmd(1'b0, 4'd0, 2'd0, 8'hFF);
    tick();
    check("rbr_b1_data",  32'(bus.data_out), 32'd2);
    check("rbr_b1_valid", 32'(bus.data_valid), 32'h1);
    tick();
    check("rbr_b2_data",  32'(bus.data_out), 32'd3);
    check("rbr_b2_valid", 32'(bus.data_valid), 32'h1);
    check("rbr_b2_done",  32'(bus.burst_done), 32'h0);
    tick();
    bus.req = 1'b0;
    check("rbr_b3_data",  32'(bus.data_out), 32'd4);
    check("rbr_b3_valid", 32'(bus.data_valid), 32'h1);
    check("rbr_b3_done",  32'(bus.burst_done), 32'h1);
    tick();
    check("rbr_valid_off", 32'(bus.data_valid), 32'h0);
    cmd(1'b1, 4'd0, 2'd0, 8'h00);
    tick();
    bus.req = 1'b0;
    check("nowr_mem0", 32'(bus.data_out), 32'd3);
    tick();

    // Reset in the middle of a 4-beat read
    cmd(1'b1, 4'd14, 2'd3, 8'h00);
    tick();
    bus.req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.data_valid), 32'h0);
    check("mrst_data",  32'(bus.data_out), 32'h00);
    check("mrst_ready", 32'(bus.ready), 32'h0);
    check("mrst_done",  32'(bus.burst_done), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mrst_ready_back", 32'(bus.ready), 32'h1);
    check("mrst_no_done",    32'(bus.burst_done), 32'h0);
    tick();
    check("mrst_no_done2",   32'(bus.burst_done), 32'h0);
    cmd(1'b1, 4'd14, 2'd3, 8'h00);
    tick();
    bus.req = 1'b0;
    check("clr14", 32'(bus.data_out), 32'h00);
    check("clr14_valid", 32'(bus.data_valid), 32'h1);
    tick();
    check("clr15", 32'(bus.data_out), 32'h00);
    tick();
    check("clr0",  32'(bus.data_out), 32'h00);
    check("clr0_done", 32'(bus.burst_done), 32'h0);
    tick();
    check("clr1",  32'(bus.data_out), 32'h00);
    check("clr1_valid", 32'(bus.data_valid), 32'h1);
    check("clr1_done", 32'(bus.burst_done), 32'h1);
    tick();

    // Write echo behaviour, then read back
    cmd(1'b0, 4'd7, 2'd0, 8'h3C);
    tick();
    bus.req = 1'b0;
`ifdef MEM_WR_ECHO_EN
    check("echo_valid", 32'(bus.data_valid), 32'h1);
    check("echo_data",  32'(bus.data_out), 32'h3C);
`else
    check("noecho_valid", 32'(bus.data_valid), 32'h0);
    check("noecho_hold",  32'(bus.data_out), 32'h00);
`endif
    tick();
    cmd(1'b1, 4'd7, 2'd0, 8'h00);
    tick();
    bus.req = 1'b0;
    check("rd7_data",  32'(bus.data_out), 32'h3C);
    check("rd7_valid", 32'(bus.data_valid), 32'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
